branch_unit: RTL and testbench
==============================

BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter ADDR_W, default 16: PC/target width; SHALL be a multiple of 8, range 8..32.
REQ-002 Parameter STK_DEPTH, default 4: return-stack entries, range 2..16.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 start  in  1  one-cycle request; cins, flags and pcin sampled when start=1 in IDLE.
REQ-006 cins  in  8  [3:0] cond sel, [4] relative, [5] call, [6] ret, [7] reserved (ignored).
REQ-007 zflag, oflag, cflag, sflag  in  1 each  ALU flags.
REQ-008 pcin  in  ADDR_W  current PC.
REQ-009 dvalid  in  1  databus byte strobe.
REQ-010 databus  in  8  target address byte, MSB first.
REQ-011 busy  out  1  high in FETCH and EXEC.
REQ-012 done  out  1  one-cycle pulse in EXEC.
REQ-013 pcoe  out  1  one-cycle taken-branch load strobe.
REQ-014 pcout  out  ADDR_W  target; 0 whenever pcoe=0.
REQ-015 stk_err  out  1  sticky stack overflow/underflow flag.

Function
REQ-016 States IDLE, FETCH, EXEC; one-hot or binary at implementer's choice.
REQ-017 IDLE+start, ret=0: latch cins/flags/pcin, clear byte counter, go FETCH.
REQ-018 IDLE+start, ret=1: latch, go EXEC directly; no bytes fetched.
REQ-019 FETCH: each dvalid shifts databus into target LSB end; after ADDR_W/8 strobes go EXEC next cycle.
REQ-020 FETCH without dvalid SHALL hold state indefinitely; dvalid in IDLE/EXEC ignored.
REQ-021 EXEC lasts exactly one cycle, asserts done, returns to IDLE; start during busy ignored.
REQ-022 Cond sel (on latched flags): 0 always, 1 z, 2 !z, 3 c, 4 c|z, 5 !(c|z), 6 !c, 7 o^s, 8 (o^s)|z, 9 !(o^s)&!z, 10 !(o^s), 11-15 never.
REQ-023 Taken: pcoe=1 in EXEC; pcout = relative ? (pcin_latched + target) mod 2^ADDR_W : target.
REQ-024 Not taken: done=1, pcoe=0, pcout=0, no stack change.
REQ-025 Latency: start to EXEC = 1 + ADDR_W/8 strobe cycles (back-to-back dvalid gives ADDR_W/8+1 cycles); ret gives 1 cycle.

Reset
REQ-026 rst SHALL force IDLE, byte counter 0, target 0, stack pointer 0, stk_err 0; busy, done, pcoe, pcout 0.
REQ-027 rst mid-FETCH/EXEC SHALL abort without pcoe and without stack change.
REQ-028 rst has priority over start/dvalid in same cycle.

Configuration
REQ-029 Macro BRANCH_UNIT_STACK_EN defined: taken call pushes pcin_latched; taken ret pops into pcout (relative bit ignored).
REQ-030 With macro: push when full -> no push, stk_err=1, branch still taken; pop when empty -> pcoe=0, stk_err=1.
REQ-031 Without macro: call treated as plain jump, ret never taken (done only), stk_err tied 0, no stack storage.

Verification
REQ-032 start cins=0x00, bytes 0x12,0x34 -> EXEC pcoe=1, pcout=0x1234, done=1.
REQ-033 cins=0x11, z=1, pcin=0xFFF0, bytes 0x00,0x20 -> pcout=0x0010 (wrap).
REQ-034 cins=0x02, z=1, bytes 0xAB,0xCD -> done=1, pcoe=0, pcout=0.
REQ-035 Stack on: call pcin=0x0100 to 0x2000, then ret cins=0x40 -> pcoe=1, pcout=0x0100; extra ret -> pcoe=0, stk_err=1.
REQ-036 rst after first byte 0x12, then full jump 0x5678 -> pcout=0x5678, no stale byte.
REQ-037 Stack on, STK_DEPTH=2: three taken calls -> third still pcoe=1, stk_err=1; two rets return first two pcins.

Source files
------------

// File: rtl/branch_unit.sv
// -----------------------------------------------------------------------------
// branch_unit
//   Conditional branch / call / return sequencer. A one-cycle start in IDLE
//   latches the instruction byte, ALU flags and current PC. For jumps and calls
//   the target address is collected MSB-first from databus (ADDR_W/8 strobes).
//   Returns go straight to EXEC. EXEC lasts one cycle: done pulses, and a taken
//   branch raises pcoe with the target on pcout.
//
//   Optional feature: define BRANCH_UNIT_STACK_EN to add a STK_DEPTH-entry
//   return stack (taken call pushes the latched PC, taken ret pops into pcout,
//   overflow/underflow set the sticky stk_err flag). Without it, a call is a
//   plain jump, ret is never taken and stk_err is tied low.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle request (sampled in IDLE only)
//   cins[7:0]                [3:0] cond sel, [4] relative, [5] call, [6] ret
//   zflag/oflag/cflag/sflag  ALU flags
//   pcin[ADDR_W-1:0]         current PC
//   dvalid, databus[7:0]     target byte strobe / data, MSB first
//   busy                     high in FETCH and EXEC
//   done                     one-cycle pulse in EXEC
//   pcoe, pcout              taken-branch strobe and target (pcout 0 otherwise)
//   stk_err                  sticky stack overflow/underflow
// -----------------------------------------------------------------------------
module branch_unit #(
    parameter int ADDR_W    = 16,
    parameter int STK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        cins,
    input  logic              zflag,
    input  logic              oflag,
    input  logic              cflag,
    input  logic              sflag,
    input  logic [ADDR_W-1:0] pcin,
    input  logic              dvalid,
    input  logic [7:0]        databus,
    output logic              busy,
    output logic              done,
    output logic              pcoe,
    output logic [ADDR_W-1:0] pcout,
    output logic              stk_err
);

    localparam int NBYTES = ADDR_W / 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [7:0]          cins_r, cins_s;
    logic [3:0]          flags_r, flags_s;     // {z, o, c, s}
    logic [ADDR_W-1:0]   pcin_r, pcin_s;
    logic [ADDR_W-1:0]   target_r, target_s;

    logic                busy_r, done_r, pcoe_r;
    logic [ADDR_W-1:0]   pcout_r;

    logic                exec_entry_s, cond_s, ret_s, call_s;
    logic [ADDR_W-1:0]   jump_s;
    logic                pcoe_s;
    logic [ADDR_W-1:0]   pcout_s;

    // Branch condition table evaluated on the latched flags {z, o, c, s}.
    function automatic logic cond_eval(input logic [3:0] sel, input logic [3:0] f);
        logic z, o, c, s;
        {z, o, c, s} = f;
        case (sel)
            4'd0:    cond_eval = 1'b1;
            4'd1:    cond_eval = z;
            4'd2:    cond_eval = ~z;
            4'd3:    cond_eval = c;
            4'd4:    cond_eval = c | z;
            4'd5:    cond_eval = ~(c | z);
            4'd6:    cond_eval = ~c;
            4'd7:    cond_eval = o ^ s;
            4'd8:    cond_eval = (o ^ s) | z;
            4'd9:    cond_eval = ~(o ^ s) & ~z;
            4'd10:   cond_eval = ~(o ^ s);
            default: cond_eval = 1'b0;
        endcase
    endfunction

    // Next-state, request latching and target byte collection.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        cins_s   = cins_r;
        flags_s  = flags_r;
        pcin_s   = pcin_r;
        target_s = target_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    cins_s   = cins;
                    flags_s  = {zflag, oflag, cflag, sflag};
                    pcin_s   = pcin;
                    cnt_s    = {CNT_W{1'b0}};
                    target_s = {ADDR_W{1'b0}};
                    state_s  = cins[6] ? S_EXEC : S_FETCH;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (dvalid) begin
                    target_s = (target_r << 4'd8) | ADDR_W'(databus);
                    if (cnt_r == CNT_W'(NBYTES - 1)) begin
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = S_EXEC;
                    end else begin
                        cnt_s = cnt_r + 3'd1;
                    end
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_EXEC:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Decode of the request as it will stand during the EXEC cycle.
    always_comb begin
        exec_entry_s = (state_s == S_EXEC);
        ret_s        = cins_s[6];
        call_s       = cins_s[5];
        cond_s       = cond_eval(cins_s[3:0], flags_s);
        if (cins_s[4]) begin
            jump_s = pcin_s + target_s;
        end else begin
            jump_s = target_s;
        end
    end

`ifdef BRANCH_UNIT_STACK_EN
    localparam int SP_W  = $clog2(STK_DEPTH + 1);
    localparam int IDX_W = $clog2(STK_DEPTH);

    logic [ADDR_W-1:0] stk_r [STK_DEPTH];
    logic [SP_W-1:0]   sp_r;
    logic              stk_err_r;
    logic              push_r, pop_r;
    logic              push_s, pop_s, err_s;
    logic [IDX_W-1:0]  top_idx_s;

    assign top_idx_s = IDX_W'(sp_r - {{(SP_W-1){1'b0}}, 1'b1});
`endif

    // EXEC outcome: taken/not-taken, target selection and stack requests.
    always_comb begin
        pcoe_s  = 1'b0;
        pcout_s = {ADDR_W{1'b0}};
`ifdef BRANCH_UNIT_STACK_EN
        push_s  = 1'b0;
        pop_s   = 1'b0;
        err_s   = 1'b0;
`endif
        if (exec_entry_s && cond_s) begin
            if (ret_s) begin
`ifdef BRANCH_UNIT_STACK_EN
                if (sp_r == {SP_W{1'b0}}) begin
                    err_s = 1'b1;
                end else begin
                    pop_s   = 1'b1;
                    pcoe_s  = 1'b1;
                    pcout_s = stk_r[top_idx_s];
                end
`else
                pcoe_s = 1'b0;
`endif
            end else begin
                pcoe_s  = 1'b1;
                pcout_s = jump_s;
`ifdef BRANCH_UNIT_STACK_EN
                if (call_s) begin
                    if (sp_r == SP_W'(STK_DEPTH)) begin
                        err_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                    end
                end else begin
                    push_s = 1'b0;
                end
`endif
            end
        end else begin
            pcoe_s = 1'b0;
        end
    end

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            cins_r   <= 8'h00;
            flags_r  <= 4'h0;
            pcin_r   <= {ADDR_W{1'b0}};
            target_r <= {ADDR_W{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            pcoe_r   <= 1'b0;
            pcout_r  <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            cins_r   <= cins_s;
            flags_r  <= flags_s;
            pcin_r   <= pcin_s;
            target_r <= target_s;
            busy_r   <= (state_s != S_IDLE);
            done_r   <= exec_entry_s;
            pcoe_r   <= pcoe_s;
            pcout_r  <= pcout_s;
        end
    end

`ifdef BRANCH_UNIT_STACK_EN
    // Stack pointer and error flag. Push/pop decided on EXEC entry are only
    // committed when EXEC completes, so a reset during EXEC leaves the stack alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp_r      <= {SP_W{1'b0}};
            stk_err_r <= 1'b0;
            push_r    <= 1'b0;
            pop_r     <= 1'b0;
        end else begin
            push_r <= push_s;
            pop_r  <= pop_s;
            if (err_s) begin
                stk_err_r <= 1'b1;
            end else begin
                stk_err_r <= stk_err_r;
            end
            if ((state_r == S_EXEC) && push_r) begin
                sp_r <= sp_r + {{(SP_W-1){1'b0}}, 1'b1};
            end else if ((state_r == S_EXEC) && pop_r) begin
                sp_r <= sp_r - {{(SP_W-1){1'b0}}, 1'b1};
            end else begin
                sp_r <= sp_r;
            end
        end
    end

    // Stack storage; contents are don't-care above the stack pointer.
    always_ff @(posedge clk) begin
        if (!rst && (state_r == S_EXEC) && push_r) begin
            stk_r[sp_r[IDX_W-1:0]] <= pcin_r;
        end
    end

    assign stk_err = stk_err_r;
`else
    assign stk_err = 1'b0;
`endif

    assign busy  = busy_r;
    assign done  = done_r;
    assign pcoe  = pcoe_r;
    assign pcout = pcout_r;

endmodule

// File: tb/tb_branch_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_unit
//   Self-checking bench for branch_unit. Directed scenarios plus randomized
//   jumps/calls/returns with random strobe gaps, ignored start/dvalid noise and
//   occasional mid-fetch resets, all checked against a behavioural model that
//   evaluates the condition table, relative arithmetic and a queue-based stack.
// -----------------------------------------------------------------------------
module tb_branch_unit;

    localparam int AW = 16;
    localparam int SD = 4;
    localparam int NB = AW / 8;

    logic          clk = 1'b0;
    logic          rst, start, zflag, oflag, cflag, sflag, dvalid;
    logic [7:0]    cins, databus;
    logic [AW-1:0] pcin, pcout;
    logic          busy, done, pcoe, stk_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] mdl_stk[$];
    bit            mdl_err;

    always #5 clk = ~clk;

    branch_unit #(.ADDR_W(AW), .STK_DEPTH(SD)) dut (
        .clk(clk), .rst(rst), .start(start), .cins(cins),
        .zflag(zflag), .oflag(oflag), .cflag(cflag), .sflag(sflag),
        .pcin(pcin), .dvalid(dvalid), .databus(databus),
        .busy(busy), .done(done), .pcoe(pcoe), .pcout(pcout), .stk_err(stk_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_ok(input int sel, input bit z, input bit o, input bit c, input bit s);
        case (sel)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return c;
            4:  return c || z;
            5:  return !(c || z);
            6:  return !c;
            7:  return o != s;
            8:  return (o != s) || z;
            9:  return (o == s) && !z;
            10: return o == s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_done"},  32'(done),  32'd0);
        chk({tag, "_pcoe"},  32'(pcoe),  32'd0);
        chk({tag, "_pcout"}, 32'(pcout), 32'd0);
        chk({tag, "_err"},   32'(stk_err), 32'(mdl_err));
    endtask

    // Reset with start/dvalid held high to show reset wins.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dvalid = 1'b1; cins = 8'h00; databus = 8'hA5;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0; dvalid = 1'b0;
        mdl_stk.delete();
        mdl_err = 1'b0;
        chk_idle("reset");
    endtask

    // One request. abort_at >= 0 asserts rst after that byte (FETCH only).
    task automatic do_branch(input logic [7:0] c, input logic [3:0] fl,
                             input logic [AW-1:0] pc, input logic [AW-1:0] tgt,
                             input int abort_at);
        bit            ok, exp_oe;
        logic [AW-1:0] exp_pc;
        @(negedge clk);
        start = 1'b1; cins = c; {zflag, oflag, cflag, sflag} = fl; pcin = pc;
        dvalid = 1'($urandom); databus = 8'($urandom);
        @(negedge clk);
        start = 1'b0; dvalid = 1'b0;
        cins = 8'($urandom); {zflag, oflag, cflag, sflag} = 4'($urandom); pcin = AW'($urandom);
        chk("start_busy", 32'(busy), 32'd1);
        if (!c[6]) begin
            for (int b = 0; b < NB; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    start = 1'($urandom); databus = 8'($urandom);
                    @(negedge clk);
                    start = 1'b0;
                    chk("hold_busy",  32'(busy),  32'd1);
                    chk("hold_done",  32'(done),  32'd0);
                    chk("hold_pcout", 32'(pcout), 32'd0);
                end
                dvalid = 1'b1; databus = tgt[AW-1-8*b -: 8];
                @(negedge clk);
                dvalid = 1'b0; databus = 8'($urandom);
                if (abort_at == b) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    mdl_stk.delete();
                    mdl_err = 1'b0;
                    chk_idle("abort");
                    return;
                end
            end
        end
        ok     = cond_ok(int'(c[3:0]), fl[3], fl[2], fl[1], fl[0]);
        exp_oe = 1'b0;
        exp_pc = '0;
        if (c[6]) begin
`ifdef BRANCH_UNIT_STACK_EN
            if (ok) begin
                if (mdl_stk.size() == 0) begin
                    mdl_err = 1'b1;
                end else begin
                    exp_oe = 1'b1;
                    exp_pc = mdl_stk.pop_back();
                end
            end
`endif
        end else if (ok) begin
            exp_oe = 1'b1;
            exp_pc = c[4] ? AW'(pc + tgt) : tgt;
`ifdef BRANCH_UNIT_STACK_EN
            if (c[5]) begin
                if (mdl_stk.size() == SD) mdl_err = 1'b1;
                else mdl_stk.push_back(pc);
            end
`endif
        end
        chk("exec_done",  32'(done),    32'd1);
        chk("exec_busy",  32'(busy),    32'd1);
        chk("exec_pcoe",  32'(pcoe),    32'(exp_oe));
        chk("exec_pcout", 32'(pcout),   32'(exp_pc));
        chk("exec_err",   32'(stk_err), 32'(mdl_err));
        @(negedge clk);
        chk_idle("post");
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; dvalid = 1'b0; cins = 8'h00; databus = 8'h00;
        zflag = 1'b0; oflag = 1'b0; cflag = 1'b0; sflag = 1'b0; pcin = '0;
        mdl_err = 1'b0;

        do_reset();
        do_branch(8'h00, 4'b0000, 16'h0000, 16'h1234, -1);   // plain jump
        do_branch(8'h11, 4'b1000, 16'hFFF0, 16'h0020, -1);   // relative wrap
        do_branch(8'h02, 4'b1000, 16'h0000, 16'hABCD, -1);   // not taken
        do_branch(8'h00, 4'b0000, 16'h0000, 16'h1234, 0);    // reset after first byte
        do_branch(8'h00, 4'b0000, 16'h0000, 16'h5678, -1);   // no stale byte

        // Call then returns (extra ret underflows when the stack exists).
        do_branch(8'h20, 4'b0000, 16'h0100, 16'h2000, -1);
        do_branch(8'h40, 4'b0000, 16'h0000, 16'h0000, -1);
        do_branch(8'h40, 4'b0000, 16'h0000, 16'h0000, -1);

        // Overflow: one more call than the stack holds, then drain.
        do_reset();
        for (int i = 0; i <= SD; i++)
            do_branch(8'h20, 4'b0000, AW'(16'h0300 + i), AW'(16'h4000 + i), -1);
        for (int i = 0; i <= SD; i++)
            do_branch(8'h40, 4'b0000, 16'h0000, 16'h0000, -1);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [7:0] c;
            int         ab;
            c = 8'($urandom);
            if ($urandom_range(0, 3) != 0) c[3:0] = 4'($urandom_range(0, 10));
            c[6] = ($urandom_range(0, 3) == 0);
            ab = (!c[6] && NB > 1 && $urandom_range(0, 15) == 0) ? 0 : -1;
            do_branch(c, 4'($urandom), AW'($urandom), AW'($urandom), ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
